chain_vector_checker: RTL

Self-checking stimulus/response stage for the XOR/NOT primitive chain used in the correctness suite. It drives every input vector into the chain's `in` bus and waits a settle window. It then compares the chain's `out` bus against a sequential golden model and reports a pass/fail verdict with first-failure capture. It sits on both sides of the chain under test: its `dut_in` feeds the chain and it consumes the chain's result on `dut_out`.

---
 rtl/chain_check_pkg.sv | 18 +
 rtl/chain_step_model.sv | 17 +
 rtl/chain_vector_checker.sv | 130 +++++++++++++
 3 files changed

// File: rtl/chain_check_pkg.sv
// Shared types and constants for the chain vector checker.
package chain_check_pkg;

   typedef enum logic [1:0] {
      IDLE,
      EVAL,
      COMPARE,
      DONE
   } state_t;

   localparam int unsigned ERR_W = 16;

   function automatic int unsigned eval_cycles(input int unsigned depth,
                                               input int unsigned settle);
      return (depth > settle) ? depth : settle;
   endfunction

endpackage

// File: rtl/chain_step_model.sv
// One golden XOR/NOT primitive step across all (odd, even) bit pairs.
module chain_step_model #(
   parameter int unsigned IO_PAIRS = 2
) (
   input  logic [2*IO_PAIRS-1:0] step_i,
   output logic [2*IO_PAIRS-1:0] step_o
);

   always_comb begin
      step_o = '0;
      for (int unsigned j = 0; j < IO_PAIRS; j++) begin
         step_o[2*j+1] = step_i[2*j+1] ^ step_i[2*j];
         step_o[2*j]   = ~step_i[2*j];
      end
   end

endmodule

// File: rtl/chain_vector_checker.sv
// Exhaustive stimulus/response checker for the XOR/NOT chain.
// Define CHECKER_STOP_ON_FAIL_EN to end the run at the first mismatch.
module chain_vector_checker
   import chain_check_pkg::*;
#(
   parameter int unsigned IO_PAIRS = 2,
   parameter int unsigned DEPTH    = 1,
   parameter int unsigned SETTLE   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic [2*IO_PAIRS-1:0] dut_in,
   input  logic [2*IO_PAIRS-1:0] dut_out,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [ERR_W-1:0]      err_count,
   output logic [2*IO_PAIRS-1:0] fail_vec,
   output logic [2*IO_PAIRS-1:0] fail_exp,
   output logic [2*IO_PAIRS-1:0] fail_got
);

   localparam int unsigned W           = 2 * IO_PAIRS;
   localparam int unsigned EVAL_CYCLES = eval_cycles(DEPTH, SETTLE);
   localparam int unsigned CW          = $clog2(EVAL_CYCLES + 1);
   localparam logic [W:0]  LAST_VEC    = (W+1)'((1 << W) - 1);
`ifdef CHECKER_STOP_ON_FAIL_EN
   localparam bit STOP_ON_FAIL = 1'b1;
`else
   localparam bit STOP_ON_FAIL = 1'b0;
`endif

   state_t            state_q;
   logic [W:0]        vec_q;
   logic [W-1:0]      dut_in_q, model_q, step_o;
   logic [CW-1:0]     cyc_q;
   logic              busy_q, done_q, pass_q;
   logic [ERR_W-1:0]  err_q, err_d;
   logic [W-1:0]      fail_vec_q, fail_exp_q, fail_got_q;
   logic              mismatch, finish;

   chain_step_model #(.IO_PAIRS(IO_PAIRS)) u_step (
      .step_i(model_q),
      .step_o(step_o)
   );

   always_comb begin
      mismatch = (dut_out != model_q);
      err_d    = err_q;
      if (mismatch && (err_q != '1)) err_d = err_q + 1'b1;
      finish   = (vec_q == LAST_VEC) || (STOP_ON_FAIL && mismatch);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         vec_q      <= '0;
         dut_in_q   <= '0;
         model_q    <= '0;
         cyc_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         err_q      <= '0;
         fail_vec_q <= '0;
         fail_exp_q <= '0;
         fail_got_q <= '0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  state_q    <= EVAL;
                  vec_q      <= '0;
                  dut_in_q   <= '0;
                  model_q    <= '0;
                  cyc_q      <= '0;
                  busy_q     <= 1'b1;
                  done_q     <= 1'b0;
                  pass_q     <= 1'b0;
                  err_q      <= '0;
                  fail_vec_q <= '0;
                  fail_exp_q <= '0;
                  fail_got_q <= '0;
               end
            end
            EVAL: begin
               // Model settles after DEPTH steps; extra SETTLE cycles just hold it.
               if (cyc_q < CW'(DEPTH)) model_q <= step_o;
               if (cyc_q == CW'(EVAL_CYCLES - 1)) begin
                  state_q <= COMPARE;
                  cyc_q   <= '0;
               end else begin
                  cyc_q <= cyc_q + 1'b1;
               end
            end
            COMPARE: begin
               err_q <= err_d;
               if (mismatch && (err_q == '0)) begin
                  fail_vec_q <= dut_in_q;
                  fail_exp_q <= model_q;
                  fail_got_q <= dut_out;
               end
               if (finish) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  pass_q  <= (err_d == '0);
               end else begin
                  state_q  <= EVAL;
                  vec_q    <= vec_q + 1'b1;
                  dut_in_q <= dut_in_q + 1'b1;
                  model_q  <= dut_in_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign dut_in    = dut_in_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign err_count = err_q;
   assign fail_vec  = fail_vec_q;
   assign fail_exp  = fail_exp_q;
   assign fail_got  = fail_got_q;

endmodule
